// File: rtl/bus_pkg.sv
// Shared widths, FSM state encoding and counter sizing for the system bus controller.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } bus_state_t;

  // The WAIT counter only ever needs to reach TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// Device-side bus bundle: the controller drives the access, busdev decoders answer.
interface bus_ctrl_if;
  import bus_pkg::*;

  logic              bus_en;
  logic [BUS_AW-1:0] bus_addr;
  logic              bus_we;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_SW-1:0] bus_wstrb;
  logic              bus_sel;
  logic              bus_rdy;
  logic [BUS_DW-1:0] bus_rdata;

  modport master (
    output bus_en, bus_addr, bus_we, bus_wdata, bus_wstrb,
    input  bus_sel, bus_rdy, bus_rdata
  );

  modport slave (
    input  bus_en, bus_addr, bus_we, bus_wdata, bus_wstrb,
    output bus_sel, bus_rdy, bus_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting one past the last winner.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int scan;

  // Pick the first requester at or after last+1, wrapping once around the ring.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    scan  = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan = int'(last) + 1 + i;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!valid && req[scan]) begin
        valid     = 1'b1;
        idx       = IW'(scan);
        gnt[scan] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Shared system bus sequencer: arbitrates requesters, runs one access at a time,
// and returns ack/err with a timeout for unclaimed or hung addresses.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*BUS_AW-1:0] addr,
  input  logic [NREQ*BUS_DW-1:0] wdata,
  input  logic [NREQ*BUS_SW-1:0] wstrb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [BUS_DW-1:0]    rdata,
  bus_ctrl_if.master           bus
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);

  bus_state_t        state;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     last_q;
  logic [NREQ-1:0]   gnt_q;
  logic [BUS_AW-1:0] addr_q;
  logic              we_q;
  logic [BUS_DW-1:0] wdata_q;
  logic [BUS_SW-1:0] wstrb_q;
  logic [BUS_DW-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req),
    .last  (last_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Transaction sequencer: arbitration, request latching, device wait and timeout.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            idx_q   <= arb_idx;
            gnt_q   <= arb_gnt;
            addr_q  <= addr[BUS_AW*arb_idx +: BUS_AW];
            we_q    <= we[arb_idx];
            wdata_q <= wdata[BUS_DW*arb_idx +: BUS_DW];
            wstrb_q <= wstrb[BUS_SW*arb_idx +: BUS_SW];
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (!bus.bus_sel) begin
            err_q <= 1'b1;
            state <= RESP;
          end else if (bus.bus_rdy) begin
            if (!we_q) rdata_q <= bus.bus_rdata;
            state <= RESP;
          end else begin
            cnt_q <= CNT_W'(1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // A late bus_rdy beats the timeout when both land in the same cycle.
          if (bus.bus_rdy) begin
            if (!we_q) rdata_q <= bus.bus_rdata;
            state <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          last_q <= idx_q;
          gnt_q  <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Bus side: latched fields persist; only bus_en qualifies the access.
  assign bus.bus_en    = (state == ADDR) || (state == WAIT);
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wstrb = wstrb_q;
  assign gnt           = gnt_q;

  // Requester side: one-cycle response, read data exposed only on a successful read.
  always_comb begin
    ack   = '0;
    err   = '0;
    rdata = '0;
    if (state == RESP) begin
      ack = gnt_q;
      if (err_q) err   = gnt_q;
      else       rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboard bench for bus_ctrl: directed transactions push expected responses,
// an independent monitor pops and compares on every ack.
module tb_bus_ctrl;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, gnt, ack, err;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  logic [31:0] rdata;

  bus_ctrl_if bif ();

  bus_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .gnt   (gnt),
    .ack   (ack),
    .err   (err),
    .rdata (rdata),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic        e;
    logic [31:0] rd;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh(input int i);
    logic [1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Device model: claims per dev_sel, raises bus_rdy on bus_en cycle dev_k+1 (dev_k<0: never).
  int          dev_k     = -1;
  logic        dev_sel   = 1'b0;
  logic [31:0] dev_rdata = '0;
  int          en_cnt    = 0;

  initial begin
    bif.bus_sel   = 1'b0;
    bif.bus_rdy   = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bif.bus_en) en_cnt++;
      else            en_cnt = 0;
      bif.bus_sel   = bif.bus_en && dev_sel;
      bif.bus_rdy   = bif.bus_en && (en_cnt == dev_k + 1);
      bif.bus_rdata = dev_rdata;
    end
  end

  // Monitor: every ack must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((ack != 2'b00) || (err != 2'b00)) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {ack, err}, 4'b0000);
        end else begin
          e = sb.pop_front();
          check("ack_vec", ack, oh(e.idx));
          check("err_vec", err, e.e ? oh(e.idx) : 2'b00);
          check("rdata", rdata, e.rd);
          check("ack_cycle", cyc, e.at);
        end
      end
    end
  end

  // One transaction; called at a falling edge while the DUT is in IDLE.
  task automatic run_txn(input logic [1:0] mask, input int w, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic sel, input int k, input logic [31:0] drd,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input int exp_lat, input int exp_en);
    exp_t e;
    int   en_n;
    logic acked;
    dev_sel          = sel;
    dev_k            = k;
    dev_rdata        = drd;
    addr[32*w +: 32] = a;
    wdata[32*w +: 32] = wd;
    wstrb[4*w +: 4]  = ws;
    we[w]            = wr;
    req              = mask;
    e.idx = w; e.e = exp_err; e.rd = exp_rd; e.at = cyc + exp_lat;
    sb.push_back(e);
    @(negedge clk);
    check("gnt_addr_phase", gnt, oh(w));
    check("bus_en_addr_phase", bif.bus_en, 1'b1);
    check("bus_addr", bif.bus_addr, a);
    check("bus_we", bif.bus_we, wr);
    check("bus_wdata", bif.bus_wdata, wd);
    check("bus_wstrb", bif.bus_wstrb, ws);
    en_n = 1;
    // Mid-transaction input changes must not reach the latched bus fields.
    addr[32*w +: 32]  = ~a;
    wdata[32*w +: 32] = ~wd;
    acked = 1'b0;
    for (int n = 0; n < 40 && !acked; n++) begin
      if (ack != 2'b00) acked = 1'b1;
      else begin
        @(negedge clk);
        if (bif.bus_en) en_n++;
      end
    end
    check("ack_seen", acked, 1'b1);
    check("bus_en_cycles", en_n, exp_en);
    check("bus_addr_held", bif.bus_addr, a);
    check("bus_wdata_held", bif.bus_wdata, wd);
    req[w] = 1'b0;
    @(negedge clk);
    check("gnt_clear_idle", gnt & oh(w), 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_ack_err", {ack, err}, 4'b0000);
    check("rst_bus_en", bif.bus_en, 1'b0);
    check("rst_bus_addr", bif.bus_addr, 32'h0);
    check("rst_bus_we", bif.bus_we, 1'b0);
    check("rst_bus_wdata", {bif.bus_wdata, bif.bus_wstrb}, 36'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_bus_en", bif.bus_en, 1'b0);

    // Zero-wait read from requester 1.
    run_txn(2'b10, 1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b1, 0, 32'hDEAD_BEEF,
            1'b0, 32'hDEAD_BEEF, 2, 1);

    // Both requesters hold req: grants alternate 0,1,0,1.
    for (int n = 0; n < 4; n++)
      run_txn(2'b11, n % 2, 1'b0, 32'h200 + 32'(n * 4), 32'h0, 4'h0, 1'b1, 0,
              32'hA000_0000 + 32'(n), 1'b0, 32'hA000_0000 + 32'(n), 2, 1);
    req = '0;

    // Write with three wait cycles; read data must stay 0.
    run_txn(2'b01, 0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 3, 32'hCAFE_F00D,
            1'b0, 32'h0, 5, 4);

    // Unclaimed address.
    run_txn(2'b01, 0, 1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1'b0, -1, 32'h5555_5555,
            1'b1, 32'h0, 2, 1);

    // Claimed but never ready: timeout after 16 bus_en cycles.
    run_txn(2'b01, 0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b1, -1, 32'h6666_6666,
            1'b1, 32'h0, 17, 16);

    // Ready in the final WAIT cycle wins over the timeout.
    run_txn(2'b01, 0, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 1'b1, 15, 32'h7777_7777,
            1'b0, 32'h7777_7777, 17, 16);

    // Reset while waiting aborts without ack and restores requester 0 priority.
    dev_sel = 1'b1; dev_k = -1; addr[31:0] = 32'h20; we[0] = 1'b0; req = 2'b01;
    repeat (3) @(negedge clk);
    check("pre_abort_bus_en", bif.bus_en, 1'b1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check("abort_bus_en", bif.bus_en, 1'b0);
    check("abort_gnt", gnt, 2'b00);
    check("abort_no_ack", {ack, err}, 4'b0000);
    rst = 1'b0;
    run_txn(2'b11, 0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 1'b1, 0, 32'h8888_8888,
            1'b0, 32'h8888_8888, 2, 1);
    req = '0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
